// File: rtl/oven_bake_countdown_pkg.sv
// Shared definitions for the oven bake countdown: state encoding, BCD digit
// limits, the board clock constant and the MM:SS validity / borrow helpers.
package oven_bake_countdown_pkg;

   // 50 MHz board clock: one 1 s tick every CLK_HZ cycles
   localparam int unsigned CLK_HZ = 50_000_000;

   // Largest legal tens digit for minutes/seconds, largest legal ones digit
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOADED  = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_e;

   // Time value as two BCD bytes, {tens,ones} each
   typedef struct packed {
      logic [7:0] mins;
      logic [7:0] secs;
   } mmss_t;

   // A loadable bake time: every digit in range and not 00:00
   function automatic logic mmss_valid(input mmss_t t);
      return (t.mins[3:0] <= DIGIT_MAX) && (t.mins[7:4] <= SEC_TENS_MAX) &&
             (t.secs[3:0] <= DIGIT_MAX) && (t.secs[7:4] <= SEC_TENS_MAX) &&
             (t != '0);
   endfunction

   // One-second decrement done digit by digit; 00:00 stays at 00:00
   function automatic mmss_t mmss_dec(input mmss_t t);
      mmss_t r;
      r = t;
      if (t != '0) begin
         if (t.secs[3:0] != 4'd0) begin
            r.secs[3:0] = t.secs[3:0] - 4'd1;
         end else begin
            r.secs[3:0] = DIGIT_MAX;
            if (t.secs[7:4] != 4'd0) begin
               r.secs[7:4] = t.secs[7:4] - 4'd1;
            end else begin
               r.secs[7:4] = SEC_TENS_MAX;
               if (t.mins[3:0] != 4'd0) begin
                  r.mins[3:0] = t.mins[3:0] - 4'd1;
               end else begin
                  r.mins[3:0] = DIGIT_MAX;
                  r.mins[7:4] = t.mins[7:4] - 4'd1;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// Prescaler for the bake countdown: emits a one-cycle tick every TICK_DIV
// enabled cycles. clr zeroes the count and suppresses the tick; with en low
// the partial count is held.
module oven_tick_gen
   import oven_bake_countdown_pkg::*;
#(
   parameter int unsigned TICK_DIV = CLK_HZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise advance while enabled and wrap at the tick
   always_comb begin
      cnt_d = cnt_q;
      tick  = en && !clr && (cnt_q == LAST);
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   // Prescaler register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/oven_bake_countdown.sv
// BCD MM:SS countdown for the oven bake phase: load handshake, start/pause/
// abort FSM, BCD borrow chain and expiry status.
// Optional expiry beeper enabled by defining OVEN_BEEP_EN; without it beep is
// tied low and no beep counters exist.
module oven_bake_countdown
   import oven_bake_countdown_pkg::*;
#(
   parameter int unsigned TICK_DIV   = CLK_HZ,
   parameter int unsigned BEEP_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   output logic       load_err,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       expired,
   output logic       done,
   output logic       beep
);

   state_e state_q, state_d;
   mmss_t  time_q, time_d;
   logic   done_q, done_d;
   logic   err_q, err_d;
   logic   live_q;

   mmss_t  load_val;
   mmss_t  dec_val;
   logic   load_fire;
   logic   load_ok;
   logic   tick;
   logic   pre_en;
   logic   pre_clr;

   assign load_val  = {load_min, load_sec};
   assign load_ok   = mmss_valid(load_val);
   assign load_fire = load_valid && load_ready;
   assign dec_val   = mmss_dec(time_q);

   // Prescaler runs only in RUN, holds its partial count in PAUSE, and is
   // zeroed everywhere else so a fresh start gets a full TICK_DIV period
   assign pre_en  = (state_q == ST_RUN);
   assign pre_clr = abort || !((state_q == ST_RUN) || (state_q == ST_PAUSE));

   oven_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pre_clr),
      .en    (pre_en),
      .tick  (tick)
   );

   // State, digits and registered pulses; live_q keeps load_ready low until
   // the first cycle after reset is released
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         time_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         done_q  <= done_d;
         err_q   <= err_d;
         live_q  <= 1'b1;
      end
   end

   // Next state and digits; command priority abort > pause > start > load
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         time_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_EXPIRED: begin
               if (load_fire) begin
                  if (load_ok) begin
                     state_d = ST_LOADED;
                     time_d  = load_val;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_LOADED: begin
               if (pause) begin
                  state_d = ST_LOADED;
               end else if (start) begin
                  state_d = ST_RUN;
               end else if (load_fire) begin
                  if (load_ok) begin
                     time_d = load_val;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (tick) begin
                  time_d = dec_val;
                  if (dec_val == '0) begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end else if (pause) begin
                     state_d = ST_PAUSE;
                  end
               end else if (pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (!pause && start) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
               time_d  = '0;
            end
         endcase
      end
   end

   // Status outputs decoded from the current state
   always_comb begin
      load_ready = live_q && ((state_q == ST_IDLE) || (state_q == ST_LOADED) ||
                              (state_q == ST_EXPIRED));
      running    = (state_q == ST_RUN);
      expired    = (state_q == ST_EXPIRED);
   end

   assign min_bcd  = time_q.mins;
   assign sec_bcd  = time_q.secs;
   assign done     = done_q;
   assign load_err = err_q;

`ifdef OVEN_BEEP_EN
   localparam int unsigned HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
   localparam int unsigned HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned BW   = $clog2(BEEP_TICKS + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

   logic          beep_q, beep_d;
   logic [HW-1:0] bcnt_q, bcnt_d;
   logic [BW-1:0] bleft_q, bleft_d;

   // Beep sequencer: armed by done, toggles each half period until the
   // toggle budget is spent, silenced as soon as EXPIRED is left
   always_comb begin
      beep_d  = beep_q;
      bcnt_d  = bcnt_q;
      bleft_d = bleft_q;
      if (done_d) begin
         beep_d  = 1'b0;
         bcnt_d  = '0;
         bleft_d = BW'(BEEP_TICKS);
      end else if (state_d != ST_EXPIRED) begin
         beep_d  = 1'b0;
         bcnt_d  = '0;
         bleft_d = '0;
      end else if (bleft_q == '0) begin
         beep_d = 1'b0;
      end else if (bcnt_q == HALF_LAST) begin
         bcnt_d  = '0;
         beep_d  = ~beep_q;
         bleft_d = bleft_q - BW'(1);
      end else begin
         bcnt_d = bcnt_q + HW'(1);
      end
   end

   // Beep registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beep_q  <= 1'b0;
         bcnt_q  <= '0;
         bleft_q <= '0;
      end else begin
         beep_q  <= beep_d;
         bcnt_q  <= bcnt_d;
         bleft_q <= bleft_d;
      end
   end

   assign beep = beep_q;
`else
   // No beeper in this build; BEEP_TICKS has no effect here
   assign beep = (BEEP_TICKS == 0) ? 1'b0 : 1'b0;
`endif

endmodule
